// File: rtl/stu_pkg.sv
// Shared types and defaults for the STU speculation-level controller:
// level enum, parameter defaults and saturating level step helpers.
package stu_pkg;

  typedef enum logic [1:0] {
    BYPASS       = 2'd0,
    CONSERVATIVE = 2'd1,
    OPTIMISTIC   = 2'd2
  } spec_level_t;

  localparam int NUM_CORES_DEFAULT      = 4;
  localparam int CONF_W_DEFAULT         = 4;
  localparam int PROMOTE_THR_DEFAULT    = 8;
  localparam int SQUASH_PENALTY_DEFAULT = 4;
  localparam int HOLDOFF_DEFAULT        = 16;
  localparam int PERF_CNT_W             = 32;

  function automatic spec_level_t spec_level_inc(input spec_level_t lvl);
    case (lvl)
      BYPASS:       return CONSERVATIVE;
      CONSERVATIVE: return OPTIMISTIC;
      default:      return OPTIMISTIC;
    endcase
  endfunction

  function automatic spec_level_t spec_level_dec(input spec_level_t lvl);
    case (lvl)
      OPTIMISTIC:   return CONSERVATIVE;
      CONSERVATIVE: return BYPASS;
      default:      return BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/stu_level_fsm.sv
// One core's level channel: level/confidence/holdoff state, 1-cycle event-to-level latency,
// no backpressure (freeze_i holds everything). Perf counters exist only under STU_PERF_CNT_EN.
module stu_level_fsm
  import stu_pkg::*;
#(
  parameter int CONF_W         = CONF_W_DEFAULT,
  parameter int PROMOTE_THR    = PROMOTE_THR_DEFAULT,
  parameter int SQUASH_PENALTY = SQUASH_PENALTY_DEFAULT,
  parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze_i,
  input  logic        commit_i,
  input  logic        squash_i,
  input  logic        unsafe_i,
  output spec_level_t level_o,
  output logic        level_chg_o,
  output logic        holdoff_o
`ifdef STU_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] squash_cnt_o,
  output logic [PERF_CNT_W-1:0] promote_cnt_o
`endif
);

  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CONF_W-1:0] CONF_MAX = '1;
  localparam logic [CONF_W-1:0] THR      = CONF_W'(PROMOTE_THR);
  localparam logic [CONF_W-1:0] PEN      = CONF_W'(SQUASH_PENALTY);
  localparam logic [HO_W-1:0]   HO_LOAD  = HO_W'(HOLDOFF_CYCLES);

  spec_level_t       level_q, level_d;
  logic [CONF_W-1:0] conf_q, conf_d;
  logic [HO_W-1:0]   holdoff_q, holdoff_d;
  logic              chg_q, chg_d;
  logic              promote_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= BYPASS;
      conf_q    <= '0;
      holdoff_q <= '0;
      chg_q     <= 1'b0;
    end else begin
      level_q   <= level_d;
      conf_q    <= conf_d;
      holdoff_q <= holdoff_d;
      chg_q     <= chg_d;
    end
  end

  assign promote_ok = (holdoff_q == '0) && (conf_q >= THR) && (level_q != OPTIMISTIC);

  // Event priority: unsafe > squash > promote > commit; lower ones are dropped.
  always_comb begin
    level_d   = level_q;
    conf_d    = conf_q;
    holdoff_d = holdoff_q;
    chg_d     = 1'b0;
    if (!freeze_i) begin
      if (holdoff_q != '0) holdoff_d = holdoff_q - 1'b1;
      if (unsafe_i) begin
        level_d   = BYPASS;
        conf_d    = '0;
        holdoff_d = HO_LOAD;
      end else if (squash_i) begin
        level_d = spec_level_dec(level_q);
        conf_d  = (conf_q > PEN) ? conf_q - PEN : '0;
      end else if (promote_ok) begin
        level_d = spec_level_inc(level_q);
        conf_d  = '0;
      end else if (commit_i && (conf_q != CONF_MAX)) begin
        conf_d = conf_q + 1'b1;
      end
      chg_d = (level_d != level_q);
    end
  end

  always_comb begin
    level_o     = level_q;
    level_chg_o = chg_q;
    holdoff_o   = (holdoff_q != '0);
  end

`ifdef STU_PERF_CNT_EN
  logic                  squash_evt, promote_evt;
  logic [PERF_CNT_W-1:0] squash_cnt_q, promote_cnt_q;

  assign squash_evt  = !freeze_i && !unsafe_i && squash_i;
  assign promote_evt = !freeze_i && !unsafe_i && !squash_i && promote_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_cnt_q  <= '0;
      promote_cnt_q <= '0;
    end else begin
      if (squash_evt && (squash_cnt_q != '1))   squash_cnt_q  <= squash_cnt_q + 1'b1;
      if (promote_evt && (promote_cnt_q != '1)) promote_cnt_q <= promote_cnt_q + 1'b1;
    end
  end

  assign squash_cnt_o  = squash_cnt_q;
  assign promote_cnt_o = promote_cnt_q;
`endif

endmodule

// File: rtl/stu_level_ctrl.sv
// Per-core adaptive speculation-level controller; level_o registered, events land on the next edge,
// no backpressure (freeze_i holds all channels). STU_PERF_CNT_EN adds squash/promote counters.
module stu_level_ctrl
  import stu_pkg::*;
#(
  parameter int NUM_CORES      = NUM_CORES_DEFAULT,
  parameter int CONF_W         = CONF_W_DEFAULT,
  parameter int PROMOTE_THR    = PROMOTE_THR_DEFAULT,
  parameter int SQUASH_PENALTY = SQUASH_PENALTY_DEFAULT,
  parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          freeze_i,
  input  logic [NUM_CORES-1:0]          commit_i,
  input  logic [NUM_CORES-1:0]          squash_i,
  input  logic [NUM_CORES-1:0]          unsafe_i,
  output spec_level_t [NUM_CORES-1:0]   level_o,
  output logic [NUM_CORES-1:0]          level_chg_o,
  output logic [NUM_CORES-1:0]          holdoff_o
`ifdef STU_PERF_CNT_EN
  ,
  output logic [NUM_CORES-1:0][PERF_CNT_W-1:0] squash_cnt_o,
  output logic [NUM_CORES-1:0][PERF_CNT_W-1:0] promote_cnt_o
`endif
);

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    stu_level_fsm #(
      .CONF_W         (CONF_W),
      .PROMOTE_THR    (PROMOTE_THR),
      .SQUASH_PENALTY (SQUASH_PENALTY),
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_fsm (
      .clk           (clk),
      .rst_n         (rst_n),
      .freeze_i      (freeze_i),
      .commit_i      (commit_i[g]),
      .squash_i      (squash_i[g]),
      .unsafe_i      (unsafe_i[g]),
      .level_o       (level_o[g]),
      .level_chg_o   (level_chg_o[g]),
      .holdoff_o     (holdoff_o[g])
`ifdef STU_PERF_CNT_EN
      ,
      .squash_cnt_o  (squash_cnt_o[g]),
      .promote_cnt_o (promote_cnt_o[g])
`endif
    );
  end

endmodule

// File: tb/tb_stu_level_ctrl.sv
// Scoreboard bench for stu_level_ctrl: directed steps push expected post-edge outputs,
// a monitor pops and compares after each rising edge. Counter checks under STU_PERF_CNT_EN.
module tb_stu_level_ctrl;
  import stu_pkg::*;

  localparam int NC = 4;
  localparam logic [1:0] B = 2'd0;
  localparam logic [1:0] C = 2'd1;
  localparam logic [1:0] O = 2'd2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   freeze_i = 1'b0;
  logic [NC-1:0]          commit_i = '0;
  logic [NC-1:0]          squash_i = '0;
  logic [NC-1:0]          unsafe_i = '0;
  spec_level_t [NC-1:0]   level_o;
  logic [NC-1:0]          level_chg_o;
  logic [NC-1:0]          holdoff_o;
`ifdef STU_PERF_CNT_EN
  logic [NC-1:0][PERF_CNT_W-1:0] squash_cnt_o;
  logic [NC-1:0][PERF_CNT_W-1:0] promote_cnt_o;
`endif

  stu_level_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .freeze_i      (freeze_i),
    .commit_i      (commit_i),
    .squash_i      (squash_i),
    .unsafe_i      (unsafe_i),
    .level_o       (level_o),
    .level_chg_o   (level_chg_o),
    .holdoff_o     (holdoff_o)
`ifdef STU_PERF_CNT_EN
    ,
    .squash_cnt_o  (squash_cnt_o),
    .promote_cnt_o (promote_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  mask;
    logic [7:0]  lvl;
    logic [3:0]  chg;
    logic [3:0]  hold;
    logic [15:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int tag, input int core,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d core=%0d actual=%0h required=%0h", name, tag, core, act, req);
    end
  endtask

  // Monitor: one expectation per rising edge, sampled 2 time units after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int c = 0; c < NC; c++) begin
          if (e.mask[c]) begin
            chk("level", int'(e.tag), c, 32'(level_o[c]), 32'(e.lvl[2*c +: 2]));
            chk("level_chg", int'(e.tag), c, 32'(level_chg_o[c]), 32'(e.chg[c]));
            chk("holdoff", int'(e.tag), c, 32'(holdoff_o[c]), 32'(e.hold[c]));
          end
        end
      end
    end
  end

  task automatic step(input logic frz, input logic [3:0] c, input logic [3:0] s,
                      input logic [3:0] u, input logic [3:0] mask, input logic [7:0] lvl,
                      input logic [3:0] chg, input logic [3:0] hold, input int tag);
    exp_t e;
    @(negedge clk);
    freeze_i = frz;
    commit_i = c;
    squash_i = s;
    unsafe_i = u;
    e.mask = mask;
    e.lvl  = lvl;
    e.chg  = chg;
    e.hold = hold;
    e.tag  = 16'(tag);
    sb_q.push_back(e);
  endtask

  // Single-core step: events and expectations apply to `core` only.
  task automatic stepc(input int core, input logic cb, input logic sb, input logic ub,
                       input logic [1:0] lv, input logic chb, input logic hb, input int tag);
    logic [3:0] m;
    m = 4'(1 << core);
    step(1'b0, cb ? m : 4'b0, sb ? m : 4'b0, ub ? m : 4'b0, m,
         8'(lv) << (2 * core), chb ? m : 4'b0, hb ? m : 4'b0, tag);
  endtask

  task automatic quiet();
    @(negedge clk);
    freeze_i = 1'b0;
    commit_i = '0;
    squash_i = '0;
    unsafe_i = '0;
  endtask

  task automatic drain(input int tag);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #3;
    chk("drain", tag, 0, 32'(sb_q.size()), 32'd0);
  endtask

  // Continuous commits: promotion lands on every 9th edge (8 to fill, 1 to promote).
  task automatic run_to_opt(input int core, input int tag);
    for (int i = 1; i <= 18; i++)
      stepc(core, 1'b1, 1'b0, 1'b0, (i < 9) ? B : (i < 18) ? C : O,
            (i == 9) || (i == 18), 1'b0, tag + i);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog step=0 core=0 actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    for (int c = 0; c < NC; c++) begin
      chk("rst_level", 0, c, 32'(level_o[c]), 32'(B));
      chk("rst_chg", 0, c, 32'(level_chg_o[c]), 32'd0);
      chk("rst_hold", 0, c, 32'(holdoff_o[c]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Core0: promotions, saturation in OPTIMISTIC, squash then re-promote from conf 11.
    run_to_opt(0, 100);
    for (int i = 1; i <= 20; i++) stepc(0, 1'b1, 1'b0, 1'b0, O, 1'b0, 1'b0, 200 + i);
    stepc(0, 1'b0, 1'b1, 1'b0, C, 1'b1, 1'b0, 300);
    stepc(0, 1'b0, 1'b0, 1'b0, O, 1'b1, 1'b0, 301);

    // Core1: OPTIMISTIC conf 6, three squashes, then conf must restart from 0.
    run_to_opt(1, 400);
    for (int i = 1; i <= 6; i++) stepc(1, 1'b1, 1'b0, 1'b0, O, 1'b0, 1'b0, 500 + i);
    stepc(1, 1'b0, 1'b1, 1'b0, C, 1'b1, 1'b0, 510);
    stepc(1, 1'b0, 1'b1, 1'b0, B, 1'b1, 1'b0, 511);
    stepc(1, 1'b0, 1'b1, 1'b0, B, 1'b0, 1'b0, 512);
    for (int i = 1; i <= 8; i++) stepc(1, 1'b1, 1'b0, 1'b0, B, 1'b0, 1'b0, 520 + i);
    stepc(1, 1'b0, 1'b0, 1'b0, C, 1'b1, 1'b0, 530);

    // Core2: unsafe beats squash and commit; holdoff blocks promotion for 16 cycles.
    run_to_opt(2, 600);
    stepc(2, 1'b1, 1'b1, 1'b1, B, 1'b1, 1'b1, 700);
    for (int i = 1; i <= 15; i++) stepc(2, 1'b1, 1'b0, 1'b0, B, 1'b0, 1'b1, 700 + i);
    stepc(2, 1'b0, 1'b0, 1'b0, B, 1'b0, 1'b0, 716);
    stepc(2, 1'b0, 1'b0, 1'b0, C, 1'b1, 1'b0, 717);

    // All cores at once, then freeze with events, then holdoff must still run 16 cycles.
    step(1'b0, 4'b0100, 4'b0001, 4'b1010, 4'b1111, {B, C, B, C}, 4'b0011, 4'b1010, 800);
    for (int i = 1; i <= 5; i++)
      step(1'b1, 4'b1111, 4'b0100, 4'b0001, 4'b1111, {B, C, B, C}, 4'b0000, 4'b1010, 810 + i);
    for (int i = 1; i <= 15; i++)
      step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, {B, C, B, C}, 4'b0000, 4'b1010, 820 + i);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, {B, C, B, C}, 4'b0000, 4'b0000, 840);

    // Core3: two promotions, three squashes.
    run_to_opt(3, 900);
    stepc(3, 1'b0, 1'b1, 1'b0, C, 1'b1, 1'b0, 950);
    stepc(3, 1'b0, 1'b1, 1'b0, B, 1'b1, 1'b0, 951);
    stepc(3, 1'b0, 1'b1, 1'b0, B, 1'b0, 1'b0, 952);
    quiet();
    drain(960);

`ifdef STU_PERF_CNT_EN
    chk("squash_cnt", 970, 3, squash_cnt_o[3], 32'd3);
    chk("promote_cnt", 970, 3, promote_cnt_o[3], 32'd2);
    chk("squash_cnt", 970, 0, squash_cnt_o[0], 32'd2);
    chk("promote_cnt", 970, 0, promote_cnt_o[0], 32'd3);
`endif

    // Leave state non-idle, then reset asynchronously between edges.
    step(1'b0, 4'b0000, 4'b0001, 4'b0010, 4'b1111, {B, C, B, B}, 4'b0001, 4'b0010, 1000);
    quiet();
    drain(1001);
    #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      chk("arst_level", 1002, c, 32'(level_o[c]), 32'(B));
      chk("arst_chg", 1002, c, 32'(level_chg_o[c]), 32'd0);
      chk("arst_hold", 1002, c, 32'(holdoff_o[c]), 32'd0);
    end
`ifdef STU_PERF_CNT_EN
    chk("arst_squash_cnt", 1002, 0, squash_cnt_o[0], 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, {B, B, B, B}, 4'b0000, 4'b0000, 1010);
    quiet();
    drain(1011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
